hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: PERF_W, 32, width of each performance counter.
REQ-002 Ports: clk in 1, sole clock; all state updates on rising edge.
REQ-003 Ports: reset in 1, asynchronous, active-high.
REQ-004 Ports: i_busy in 1, fetch waiting on instruction memory.
REQ-005 Ports: d_busy in 1, memory access in commit stage outstanding.
REQ-006 Ports: mdu_busy in 1, multi-cycle mult/div occupying execute.
REQ-007 Ports: rob_full in 1, ROB cannot accept renamed instructions.
REQ-008 Ports: iq_full in 1, issue queue cannot accept instructions.
REQ-009 Ports: exception_valid in 1 and pcexception in 32, exception redirect request and target.
REQ-010 Ports: branch_taken in 1 and pcbranch in 32, mispredict redirect request from ROB and target.
REQ-011 Ports: stallF, stallD, stallR, stallI, stallE, stallC out 1 each, hold the corresponding pipeline register.
REQ-012 Ports: flushF, flushD, flushR, flushI, flushE, flushC out 1 each, clear the corresponding pipeline register.
REQ-013 Ports: redirect_valid out 1 and pc_redirect out 32, PC override to pcselect.
REQ-014 Ports: perf_stall, perf_flush, perf_wait out PERF_W each.

Function
REQ-015 FSM SHALL have states RUN, WAIT_D, FLUSH, DISCARD_I.
REQ-016 RUN stall sources SHALL be: C = d_busy; E = mdu_busy; I = 0; R = rob_full|iq_full; D = 0; F = i_busy.
REQ-017 In RUN, each stage stall SHALL be its own source OR the next-downstream stall (C downstream of E, E of I, ... D of F).
REQ-018 In RUN, a stage X+1 SHALL be flushed (bubble) when stage X is stalled and stage X+1 is not; flushF SHALL be 0.
REQ-019 In RUN, a request (exception_valid|branch_taken) SHALL latch the target, exception winning if both; next state WAIT_D if d_busy, else FLUSH.
REQ-020 WAIT_D: all stalls 1, all flushes 0; exception_valid SHALL overwrite a latched branch target, never the reverse; leave to FLUSH in the cycle after d_busy is sampled 0.
REQ-021 FLUSH (exactly one cycle): all six flushes 1, all stalls 0, redirect_valid 1, pc_redirect = latched target; next DISCARD_I if i_busy, else RUN.
REQ-022 DISCARD_I: stallF 1, flushD 1, other stalls 0 and other flushes 0; redirect_valid 0; return to RUN in the cycle after i_busy is sampled 0.
REQ-023 Requests in FLUSH or DISCARD_I SHALL be ignored; a simulation assertion SHALL flag them.
REQ-024 Redirect latency: redirect_valid SHALL assert exactly one cycle after the request when d_busy=0.
REQ-025 Outside FLUSH, redirect_valid SHALL be 0 and pc_redirect SHALL hold its last value.

Reset
REQ-026 Reset SHALL force state RUN, latched target 0, counters 0, and all stall, flush and redirect outputs 0, regardless of the current state.
REQ-027 After reset release, outputs SHALL follow REQ-016..018 combinationally from the inputs.

Configuration
REQ-028 Macro HAZARD_PERF_EN SHALL compile in three saturating counters:
- perf_stall: RUN cycles with stallF=1.
- perf_flush: entries into FLUSH.
- perf_wait: cycles in WAIT_D.
REQ-029 Without HAZARD_PERF_EN, the perf ports SHALL remain and be driven constant 0, with no counter flops.

Structure
REQ-030 hazard_pkg SHALL hold hazard_state_t (the four states) and the PERF_W default constant.
REQ-031 Sub-module hazard_perf_cnt (saturating PERF_W counter with enable) SHALL be instantiated three times under HAZARD_PERF_EN.

Verification
REQ-032 Bench SHALL cover: rob_full=1 in RUN -> stallF=stallD=stallR=1, flushI=1, stallI=stallE=stallC=0.
REQ-033 Bench SHALL cover: exception_valid with pcexception=0xBFC00380 and branch_taken with pcbranch=0x80001000 in the same cycle, d_busy=0 -> next cycle redirect_valid=1, pc_redirect=0xBFC00380, all flushes 1.
REQ-034 Bench SHALL cover: branch_taken with pcbranch=0x80001000 while d_busy=1 for 3 cycles, exception with pcexception=0xBFC00380 on WAIT_D cycle 2 -> all stalls 1 for 3 cycles, then FLUSH with pc_redirect=0xBFC00380.
REQ-035 Bench SHALL cover: FLUSH entered with i_busy=1 held 2 more cycles -> DISCARD_I for 2 cycles (stallF=1, flushD=1), then RUN.
REQ-036 Bench SHALL cover: reset asserted in WAIT_D -> outputs 0 immediately (asynchronous), state RUN after release.
REQ-037 Bench SHALL cover, with HAZARD_PERF_EN and PERF_W=4: 20 cycles of i_busy in RUN -> perf_stall saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : controller modes (normal run, wait for commit-stage
//                    memory, one-cycle flush/redirect, discard fetch)
//   PERF_W_DEFAULT : default width of the performance counters
//   ST_*           : bit positions of the six pipeline stages inside the
//                    internal stall/flush vectors (F upstream ... C downstream)
// ----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_D,
    FLUSH,
    DISCARD_I
  } hazard_state_t;

  localparam int PERF_W_DEFAULT = 32;

  localparam int STAGE_N = 6;
  localparam int ST_F    = 0;
  localparam int ST_D    = 1;
  localparam int ST_R    = 2;
  localparam int ST_I    = 3;
  localparam int ST_E    = 4;
  localparam int ST_C    = 5;

endpackage

// File: rtl/hazard_perf_cnt.sv
// ----------------------------------------------------------------------------
// hazard_perf_cnt
// Saturating event counter: counts clock cycles with en=1, sticks at all-ones.
//   clk   : clock, rising edge
//   reset : asynchronous active-high clear
//   en    : count this cycle
//   count : current value (W bits)
// ----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush/redirect controller for a six-stage pipeline
// (F fetch, D decode, R rename, I issue, E execute, C commit).
//
// Ports
//   clk, reset                  : clock; asynchronous active-high reset
//   i_busy, d_busy, mdu_busy    : fetch / commit-memory / mult-div busy
//   rob_full, iq_full           : rename back-pressure
//   exception_valid, pcexception: exception redirect request + target
//   branch_taken, pcbranch      : mispredict redirect request + target
//   stallF..stallC              : hold the stage's pipeline register
//   flushF..flushC              : clear the stage's pipeline register
//   redirect_valid, pc_redirect : PC override towards pcselect
//   perf_stall/flush/wait       : performance counters (PERF_W bits)
//
// Build option
//   HAZARD_PERF_EN : when defined, three saturating counters are built;
//                    otherwise the perf ports are tied to zero.
// ----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int PERF_W = PERF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_busy,
  input  logic              d_busy,
  input  logic              mdu_busy,
  input  logic              rob_full,
  input  logic              iq_full,
  input  logic              exception_valid,
  input  logic [31:0]       pcexception,
  input  logic              branch_taken,
  input  logic [31:0]       pcbranch,
  output logic              stallF,
  output logic              stallD,
  output logic              stallR,
  output logic              stallI,
  output logic              stallE,
  output logic              stallC,
  output logic              flushF,
  output logic              flushD,
  output logic              flushR,
  output logic              flushI,
  output logic              flushE,
  output logic              flushC,
  output logic              redirect_valid,
  output logic [31:0]       pc_redirect,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_wait
);

  hazard_state_t      state_q, state_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [31:0]        pc_redirect_q;
  logic [STAGE_N-1:0] run_stall, run_flush;
  logic [STAGE_N-1:0] stall_v, flush_v;
  logic               redirect_v;
  logic               request;

  assign request = exception_valid | branch_taken;

  // Back-pressure ripples upstream: a stage holds when it has its own reason
  // or anything downstream of it holds. I and D have no local source.
  logic stall_f_run, stall_d_run, stall_r_run, stall_i_run, stall_e_run, stall_c_run;

  assign stall_c_run = d_busy;
  assign stall_e_run = mdu_busy | stall_c_run;
  assign stall_i_run = stall_e_run;
  assign stall_r_run = rob_full | iq_full | stall_i_run;
  assign stall_d_run = stall_r_run;
  assign stall_f_run = i_busy | stall_d_run;

  assign run_stall = {stall_c_run, stall_e_run, stall_i_run,
                      stall_r_run, stall_d_run, stall_f_run};

  // The first running stage below the stalled block gets a bubble so the
  // held instruction is not duplicated downstream. Fetch is never bubbled.
  assign run_flush = {stall_e_run & ~stall_c_run,
                      stall_i_run & ~stall_e_run,
                      stall_r_run & ~stall_i_run,
                      stall_d_run & ~stall_r_run,
                      stall_f_run & ~stall_d_run,
                      1'b0};

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    stall_v    = '0;
    flush_v    = '0;
    redirect_v = 1'b0;

    unique case (state_q)
      RUN: begin
        stall_v = run_stall;
        flush_v = run_flush;
        if (request) begin
          tgt_d   = exception_valid ? pcexception : pcbranch;
          state_d = d_busy ? WAIT_D : FLUSH;
        end
      end

      WAIT_D: begin
        // Freeze everything until the outstanding commit access drains; a
        // late exception takes priority over an already latched branch.
        stall_v = '1;
        if (exception_valid) begin
          tgt_d = pcexception;
        end
        if (!d_busy) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        flush_v    = '1;
        redirect_v = 1'b1;
        state_d    = i_busy ? DISCARD_I : RUN;
      end

      DISCARD_I: begin
        // The fetch in flight belongs to the old path: hold F until it
        // returns and keep dropping whatever reaches D.
        stall_v[ST_F] = 1'b1;
        flush_v[ST_D] = 1'b1;
        if (!i_busy) begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      tgt_q         <= '0;
      pc_redirect_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      // Load the redirect target only on entry to FLUSH so the port keeps
      // the last redirect while a new target is being collected.
      if (state_d == FLUSH) begin
        pc_redirect_q <= tgt_d;
      end
    end
  end

  // Reset forces the outputs low at once, not only after the next edge.
  assign stallF = stall_v[ST_F] & ~reset;
  assign stallD = stall_v[ST_D] & ~reset;
  assign stallR = stall_v[ST_R] & ~reset;
  assign stallI = stall_v[ST_I] & ~reset;
  assign stallE = stall_v[ST_E] & ~reset;
  assign stallC = stall_v[ST_C] & ~reset;
  assign flushF = flush_v[ST_F] & ~reset;
  assign flushD = flush_v[ST_D] & ~reset;
  assign flushR = flush_v[ST_R] & ~reset;
  assign flushI = flush_v[ST_I] & ~reset;
  assign flushE = flush_v[ST_E] & ~reset;
  assign flushC = flush_v[ST_C] & ~reset;

  assign redirect_valid = redirect_v & ~reset;
  assign pc_redirect    = pc_redirect_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.W(PERF_W)) u_perf_stall (
    .clk   (clk),
    .reset (reset),
    .en    ((state_q == RUN) && stall_v[ST_F]),
    .count (perf_stall)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_perf_flush (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == FLUSH),
    .count (perf_flush)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_perf_wait (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == WAIT_D),
    .count (perf_wait)
  );
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_wait  = '0;
`endif

`ifndef SYNTHESIS
  // A redirect request during FLUSH or DISCARD_I is dropped by design; flag
  // it because the requester upstream would lose its redirect.
  req_ignored_a : assert property (
    @(posedge clk) disable iff (reset)
      ((state_q == FLUSH) || (state_q == DISCARD_I)) |-> !request
  ) else $error("hazard_ctrl: redirect request ignored during flush/discard");
`endif

endmodule
